// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter and its self-check users.
package clk_meter_pkg;

   localparam int DEF_W           = 8;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_LOCK_COUNT  = 4;
   localparam int MEAS_W          = DEF_W;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   typedef struct packed {
      logic [MEAS_W-1:0] period;
      logic [MEAS_W-1:0] high_time;
   } meas_t;

   // The match counter must be able to hold LOCK_COUNT itself.
   function automatic int lock_width(input int lock_count);
      return $clog2(lock_count) + 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Parameterised-depth synchroniser for asynchronous single-bit inputs.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous clock in system-clock cycles,
// delivering each completed period on a valid/ready output with lock and overflow status.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int W           = DEF_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_in,
   output logic         meas_valid,
   input  logic         meas_ready,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         locked,
   output logic         overflow,
   output logic         meas_lost
);

   localparam int              MW      = lock_width(LOCK_COUNT);
   localparam logic [W-1:0]    CNT_MAX = '1;
   localparam logic [MW-1:0]   LOCK_TH = MW'(LOCK_COUNT);

   logic          s;
   logic          s_d_q;
   logic          rise;
   state_t        state_q, state_d;
   logic [W-1:0]  per_q, per_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  period_q, period_d;
   logic [W-1:0]  high_q, high_d;
   logic [MW-1:0] match_q, match_d;
   logic          valid_q, valid_d;
   logic          locked_q, locked_d;
   logic          ovf_q, ovf_d;
   logic          lost_q, lost_d;

   sync_chain #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clk),
      .rst_ni(rst),
      .d_i   (clk_in),
      .q_o   (s)
   );

   assign rise = s & ~s_d_q;

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      hi_d     = hi_q;
      period_d = period_q;
      high_d   = high_q;
      match_d  = match_q;
      valid_d  = valid_q;
      locked_d = locked_q;
      ovf_d    = ovf_q;
      lost_d   = 1'b0;

      if (valid_q && meas_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            per_d = '0;
            hi_d  = '0;
            if (rise) begin
               per_d   = W'(1);
               hi_d    = W'(1);
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_d = per_q;
               high_d   = hi_q;
               if (per_q == period_q) begin
                  match_d = (match_q >= LOCK_TH) ? match_q : match_q + MW'(1);
               end else begin
                  match_d = MW'(1);
               end
               locked_d = (match_d >= LOCK_TH);
               // An unaccepted result is overwritten; a same-cycle transfer is not a loss.
               lost_d   = valid_q & ~meas_ready;
               valid_d  = 1'b1;
               ovf_d    = 1'b0;
               per_d    = W'(1);
               hi_d     = W'(1);
            end else if (per_q == CNT_MAX) begin
               ovf_d    = 1'b1;
               locked_d = 1'b0;
               match_d  = '0;
               per_d    = '0;
               hi_d     = '0;
               state_d  = IDLE;
            end else begin
               per_d = per_q + W'(1);
               hi_d  = hi_q + W'(s);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         s_d_q    <= 1'b0;
         per_q    <= '0;
         hi_q     <= '0;
         period_q <= '0;
         high_q   <= '0;
         match_q  <= '0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
         ovf_q    <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_d_q    <= s;
         per_q    <= per_d;
         hi_q     <= hi_d;
         period_q <= period_d;
         high_q   <= high_d;
         match_q  <= match_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         ovf_q    <= ovf_d;
         lost_q   <= lost_d;
      end
   end

   assign meas_valid = valid_q;
   assign period     = period_q;
   assign high_time  = high_q;
   assign locked     = locked_q;
   assign overflow   = ovf_q;
   assign meas_lost  = lost_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter against a rise-time based reference model.
module tb_clk_period_meter;

   localparam int W      = 4;
   localparam int SYNC   = 2;
   localparam int LOCKN  = 4;
   localparam int MAXCNT = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clkIn = 1'b0;
   logic         measReady = 1'b0;
   logic         measValid, locked, overflow, measLost;
   logic [W-1:0] period, highTime;

   clk_period_meter #(
      .W          (W),
      .SYNC_STAGES(SYNC),
      .LOCK_COUNT (LOCKN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clk_in    (clkIn),
      .meas_valid(measValid),
      .meas_ready(measReady),
      .period    (period),
      .high_time (highTime),
      .locked    (locked),
      .overflow  (overflow),
      .meas_lost (measLost)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: samples since reset release and rise-to-rise bookkeeping.
   bit xs[$];
   int cyc;
   bit measuring;
   int startCyc;
   int perHist[$];
   int expPeriod, expHigh;
   bit expValid, expLocked, expOvf, expLost;

   int patP, patH, patT;
   bit holdLow;
   int readyMode;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic bit sVal(input int idx);
      if (idx < 0 || idx >= xs.size()) return 1'b0;
      return xs[idx];
   endfunction

   function automatic bit lockedFromHist();
      int n = perHist.size();
      if (n < LOCKN) return 1'b0;
      for (int i = n - LOCKN + 1; i < n; i++) begin
         if (perHist[i] != perHist[n - LOCKN]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic modelReset();
      xs.delete();
      perHist.delete();
      cyc       = -1;
      measuring = 1'b0;
      startCyc  = 0;
      expPeriod = 0;
      expHigh   = 0;
      expValid  = 1'b0;
      expLocked = 1'b0;
      expOvf    = 1'b0;
      expLost   = 1'b0;
   endtask

   // The synchronised input during cycle n is the sample taken SYNC-1 edges earlier.
   function automatic bit riseAt(input int n);
      return sVal(n - SYNC + 1) & ~sVal(n - SYNC);
   endfunction

   task automatic modelStep(input bit rdy);
      int n = cyc;
      int hi;
      expLost = 1'b0;
      if (expValid && rdy) expValid = 1'b0;
      if (measuring && riseAt(n)) begin
         hi = 0;
         for (int c = startCyc; c < n; c++) hi += int'(sVal(c - SYNC + 1));
         expLost   = expValid;
         expValid  = 1'b1;
         expPeriod = n - startCyc;
         expHigh   = hi;
         expOvf    = 1'b0;
         perHist.push_back(expPeriod);
         expLocked = lockedFromHist();
         startCyc  = n;
      end else if (measuring && (n - startCyc) >= MAXCNT) begin
         expOvf    = 1'b1;
         expLocked = 1'b0;
         measuring = 1'b0;
         perHist.delete();
      end else if (!measuring && riseAt(n)) begin
         measuring = 1'b1;
         startCyc  = n;
      end
   endtask

   task automatic checkAll();
      checkOutput("meas_valid", measValid, expValid);
      checkOutput("meas_lost", measLost, expLost);
      checkOutput("overflow", overflow, expOvf);
      checkOutput("locked", locked, expLocked);
      checkOutput("period", period, expPeriod);
      checkOutput("high_time", highTime, expHigh);
   endtask

   task automatic setPattern(input int p, input int h);
      patP    = p;
      patH    = h;
      patT    = 0;
      holdLow = 1'b0;
   endtask

   task automatic applyStimulus();
      case (readyMode)
         0:       measReady = 1'($urandom_range(0, 1));
         1:       measReady = 1'b1;
         2:       measReady = 1'b0;
         default: measReady = riseAt(cyc);
      endcase
      if (holdLow) begin
         clkIn = 1'b0;
      end else begin
         clkIn = (patT < patH);
         patT  = (patT + 1) % patP;
      end
      xs.push_back(clkIn);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus();
         modelStep(measReady);
         cyc++;
         @(negedge clk);
         checkAll();
      end
   endtask

   task automatic pulseReset();
      rst = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int p, h;
      modelReset();
      setPattern(6, 3);
      readyMode = 1;
      rst = 1'b0;
      @(negedge clk);
      checkAll();
      @(negedge clk);
      rst = 1'b1;

      $display("[TB] basic measurement, period 6 high 3");
      runCycles(60);
      checkOutput("basic_period", period, 6);
      checkOutput("basic_high", highTime, 3);
      checkOutput("basic_locked", locked, 1);

      $display("[TB] divide-by-3 input");
      setPattern(3, 1);
      runCycles(30);
      checkOutput("div3_period", period, 3);
      checkOutput("div3_high", highTime, 1);
      checkOutput("div3_locked", locked, 1);

      $display("[TB] lock loss, period 6 then 7");
      setPattern(6, 3);
      runCycles(50);
      checkOutput("lock6_locked", locked, 1);
      setPattern(7, 3);
      runCycles(50);
      checkOutput("lock7_period", period, 7);
      checkOutput("lock7_locked", locked, 1);

      $display("[TB] backpressure, period 8");
      setPattern(8, 4);
      readyMode = 2;
      runCycles(20);
      readyMode = 3;
      runCycles(20);
      readyMode = 1;
      runCycles(10);

      $display("[TB] overflow and recovery");
      setPattern(6, 3);
      runCycles(20);
      holdLow = 1'b1;
      runCycles(24);
      checkOutput("ovf_set", overflow, 1);
      checkOutput("ovf_locked", locked, 0);
      setPattern(5, 2);
      runCycles(12);
      checkOutput("ovf_clear", overflow, 0);
      checkOutput("ovf_period", period, 5);

      $display("[TB] randomised segments");
      readyMode = 0;
      for (int seg = 0; seg < 12; seg++) begin
         p = int'($urandom_range(2, MAXCNT));
         h = int'($urandom_range(1, p - 1));
         setPattern(p, h);
         if ($urandom_range(0, 5) == 0) holdLow = 1'b1;
         runCycles(int'($urandom_range(30, 60)));
      end

      $display("[TB] reset mid-measurement");
      readyMode = 1;
      setPattern(9, 4);
      runCycles(25);
      pulseReset();
      checkOutput("rst_valid", measValid, 0);
      checkOutput("rst_period", period, 0);
      runCycles(40);
      readyMode = 0;
      runCycles(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

- Measures the period and high time of a slow, free-running or derived clock, for example the output of the divide-by-3 generator, in units of the system clock.
- Treats the measured clock as asynchronous data: it is synchronised, edge-detected and timed by counters.
- Each completed period is delivered as one result on a valid/ready output, together with lock and overflow status.
- Sits directly downstream of the clock-divider stage, as its on-chip self-check.

## Interface
- `W`, 8: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: number of synchroniser flops on `clk_in`; minimum 2.
- `LOCK_COUNT`, 4: number of consecutive identical periods needed before `locked` asserts; minimum 2.
- `clk`  in  1  system clock; all logic is on its posedge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `clk_in`  in  1  clock under measurement; sampled as asynchronous data.
- `meas_valid`  out  1  result is held and available.
- `meas_ready`  in  1  consumer accepts the result.
- `period`  out  W  clk cycles from one rising edge to the next.
- `high_time`  out  W  clk cycles with the synchronised `clk_in` high within that period.
- `locked`  out  1  the last `LOCK_COUNT` periods were identical.
- `overflow`  out  1  sticky: no rising edge seen within 2^W-1 cycles.
- `meas_lost`  out  1  one-cycle pulse: an unaccepted result was overwritten.

## Operation
- **Reset values:** all outputs are 0, the FSM is IDLE, and all counters and synchroniser flops are 0.
- **Synchroniser and edge detect:**
  - `clk_in` passes through `SYNC_STAGES` flops giving `s`, then one history flop giving `s_d`.
  - `rise = s & ~s_d`; this is combinational.
- **State IDLE:**
  - Counters are held at 0.
  - On `rise`, set `per_cnt`=1 and `hi_cnt`=1, then go to MEASURE.
- **State MEASURE:** on every cycle without `rise`:
  - `per_cnt` increments.
  - `hi_cnt` increments when `s`=1.
- **On `rise` in MEASURE:**
  - Load the result registers: `period`=`per_cnt`, `high_time`=`hi_cnt`.
  - Set `meas_valid`=1 and clear `overflow`.
  - Restart the counters: `per_cnt`=1, `hi_cnt`=1.
- **Saturation:**
  - When `per_cnt` reaches 2^W-1 without a `rise`: set `overflow`=1, clear `locked` and the match count, clear both counters, and go to IDLE.
  - `hi_cnt` never exceeds `per_cnt`, so it needs no separate check.
- **Lock:**
  - A match counter (width clog2(`LOCK_COUNT`)+1) increments, saturating, when a new `period` equals the previous one.
  - It resets to 1 on any mismatch.
  - `locked` = (match counter >= `LOCK_COUNT`).
  - `high_time` does not take part in the lock decision.
- **Output handshake:**
  - A transfer occurs when `meas_valid & meas_ready`.
  - `meas_valid` stays high with stable data until that transfer.
  - A new result while `meas_valid & ~meas_ready` overwrites the data, keeps `meas_valid` high, and pulses `meas_lost`.
  - A new result in the same cycle as a transfer: the old result is consumed, the new one loads, `meas_valid` stays 1, and `meas_lost` stays 0.
- **Reset mid-operation:**
  - Asserting `rst` clears everything immediately, including the synchroniser.
  - The first result after reset requires two rising edges.

## Timing
- **Latency:** a `clk_in` value sampled at posedge k reaches `s` at posedge k+`SYNC_STAGES`-1.
- **Result timing:** `rise` is seen during the following cycle; `meas_valid` and the data are updated at posedge k+`SYNC_STAGES`. `locked` updates in the same cycle as the data.
- **Resolution:** period and high-time resolution is one clk cycle. Input high or low phases shorter than one clk cycle may be missed.
- **Throughput:** one result per input period. The input period must be at least 2 clk cycles.
- **Registered outputs:** all outputs are registers, and there is no combinational path from `meas_ready` to any output.

## Structure
- **Package `clk_meter_pkg`:**
  - `state_t` enum {IDLE, MEASURE}.
  - Default parameter constants.
  - A `meas_t` struct {period, high_time}; it may be parameterised by a localparam W.
- **Sub-module `sync_chain`:**
  - Parameterised-depth synchroniser with async active-low reset.
  - Reused for other async inputs in the codebase.
- **Top level:** FSM, counters, lock tracker and output register.

## Test plan
- **Basic measurement:** `clk_in` period 6 clk cycles, 3 high, `meas_ready`=1.
  - Each result reads `period`=6, `high_time`=3.
  - `locked`=1 with the 4th result.
- **Divider-driven input:** `clk_in` driven by the divide-by-3 block.
  - `period`=3 every result; `high_time` constant at 1 or 2.
  - `locked`=1 after 4 results.
- **Overflow:** W=4, `clk_in` held low after one rising edge.
  - `overflow`=1 when `per_cnt` reaches 15 cycles; `locked`=0.
  - The next two edges, 5 cycles apart, give `period`=5 and clear `overflow`.
- **Backpressure:** period 8, `meas_ready`=0 for 20 cycles.
  - `meas_valid` stays high; `meas_lost` pulses at the 2nd and 3rd edges.
  - The held data is always the newest result.
  - Raise `meas_ready` in the same cycle as a new edge: no `meas_lost`, and `meas_valid` stays 1.
- **Lock loss:** locked at period 6, then switch to period 7.
  - `locked`=0 with the first result of 7.
  - `locked`=1 again with the 4th consecutive 7.
- **Reset mid-measurement:** assert `rst` for 2 cycles during a measurement.
  - All outputs return to 0 at once.
  - No result appears until the second rising edge after release.
